fu_wb_queue: RTL and testbench
==============================

# fu_wb_queue

Writeback queue sitting directly downstream of the execute stage (ALU, multiplier, load unit). It collects completed results from up to `NUM_SRC` producers per cycle and retires them in age order, one per cycle, onto the CDB, the PRF write port and the ROB done port. Buffered entries track branch masks: on a misprediction the affected entries are squashed, and on a correct prediction the resolved bit is cleared. Producers stop issuing while the queue cannot absorb a worst-case burst.

## Interface
- `DEPTH`, default 4: number of entries; must be at least `NUM_SRC`.
- `NUM_SRC`, default 3: number of producer ports; source 0 has the highest intra-cycle age priority.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `src_vld_i` in `NUM_SRC`: per-source result valid.
- `src_tag_i` in `NUM_SRC`×`PRF_IDX_W`: destination physical register.
- `src_value_i` in `NUM_SRC`×64: result value.
- `src_rob_idx_i` in `NUM_SRC`×(`ROB_IDX_W`+1): ROB index.
- `src_br_mask_i` in `NUM_SRC`×`BR_MASK_W`: branch dependency mask.
- `src_rdy_o` out 1: queue can accept a full burst next edge; shared by all sources.
- `wb_stall_i` in 1: writeback port taken by another agent this cycle; no dequeue.
- `rob_br_recovery_i` in 1: misprediction recovery pulse.
- `rob_br_pred_correct_i` in 1: correct-prediction pulse.
- `rob_br_tag_fix_i` in `BR_MASK_W`: one-hot tag of the resolving branch.
- `wb_vld_o` out 1: writeback valid; drives CDB valid, PRF write enable and ROB done.
- `wb_tag_o` out `PRF_IDX_W`: CDB tag / PRF write index.
- `wb_value_o` out 64: PRF write value.
- `wb_rob_idx_o` out `ROB_IDX_W`+1: ROB index of the completing instruction.
- `wb_br_mask_o` out `BR_MASK_W`: mask of the departing entry.
- `count_o` out clog2(`DEPTH`+1): number of occupied entries.

## Operation
- Storage is a collapsing array. Slot 0 is the oldest entry. Valid entries are always contiguous from slot 0.
- Head output:
  - `wb_vld_o` = slot0 valid & ~`wb_stall_i` & ~`rob_br_recovery_i`.
  - When `wb_vld_o` is 0: `wb_tag_o` = `ZERO_REG` and all other `wb_*` outputs are 0.
- Dequeue occurs when `wb_vld_o` is 1. The remaining entries shift down by one.
- Enqueue:
  - Valid sources are appended after the surviving entries, in ascending source index.
  - Before storing, a source's mask has the `rob_br_tag_fix_i` bit cleared when `rob_br_pred_correct_i` is high.
- `src_rdy_o` = (`count_o` ≤ `DEPTH` − `NUM_SRC`). It depends only on registered count.
- A source asserting valid while `src_rdy_o` is 0 is a protocol error. Assert it in simulation; the hardware drops the request.
- Recovery (`rob_br_recovery_i` high):
  - Every stored entry and every incoming source with (mask & `rob_br_tag_fix_i`) ≠ 0 is discarded.
  - Survivors compact in age order.
  - No dequeue happens that cycle.
- Correct prediction: the `rob_br_tag_fix_i` bit is cleared in all stored masks.
- If recovery and pred_correct are both high, recovery takes precedence and pred_correct is ignored.

## Timing
- Reset (`rst_n` low, asynchronous): all entries are invalid, `count_o` = 0, `wb_vld_o` = 0, `wb_tag_o` = `ZERO_REG`, other outputs are 0, and `src_rdy_o` = 1.
  - Reset mid-operation discards all contents immediately, without waiting for a clock edge.
- Latency: a result enqueued at edge N appears at the head no earlier than cycle N+1. With `WBQ_BYPASS_EN` defined, an empty queue gives 0 cycles.
- Throughput is one writeback per cycle. Within one cycle, dequeue, squash and enqueue resolve in that order, and the result is registered at the edge.
- Full with dequeue: `src_rdy_o` still uses the registered count. No same-cycle credit return.
- Empty with all sources valid: all are accepted; source 0 writes back first.

## Configuration
- `WBQ_BYPASS_EN` defined:
  - When the queue is empty, `wb_stall_i` is low, recovery is low and any source is valid, the lowest-index valid source drives the `wb_*` outputs combinationally in the same cycle.
  - That source is not stored; the other valid sources are enqueued.
- `WBQ_BYPASS_EN` undefined: every result passes through storage, giving 1-cycle minimum latency.

## Structure
- Shared package holds:
  - `wbq_entry_t` struct: vld, tag, value, rob_idx, br_mask.
  - The width macros `PRF_IDX_W`, `ROB_IDX_W` and `BR_MASK_W`, plus `ZERO_REG`.
- One sub-module, `wbq_squash`: combinational per-entry kill/clear of the branch mask, instantiated for both the stored entries and the incoming source paths.

## Test plan
- Reset, then source 0 valid with tag 12, value 0xAB, rob 5 → next cycle `wb_vld_o`=1, `wb_tag_o`=12, `wb_value_o`=0xAB, `wb_rob_idx_o`=5; `count_o` returns to 0.
- All 3 sources valid in one cycle (tags 4, 7, 9) → writebacks in order 4, 7, 9 on three consecutive cycles; `src_rdy_o` drops to 0 while `count_o` > 1.
- Queue holds masks 0b01, 0b10, 0b01; recovery with tag_fix 0b01 → only the 0b10 entry survives and writes back next; `wb_vld_o`=0 during the recovery cycle.
- pred_correct with tag_fix 0b10 while holding an entry with mask 0b11 → that entry later departs with `wb_br_mask_o`=0b01.
- `wb_stall_i` held for 2 cycles with 2 entries → no output for those cycles, then both entries drain in order; no loss.
- Assert `rst_n` mid-burst → outputs clear immediately; after release, `count_o`=0 and `src_rdy_o`=1.

Source files
------------

// File: rtl/fu_wb_queue_pkg.sv
// rtl/fu_wb_queue_pkg.sv - shared widths, zero register and entry type for the writeback queue
package fu_wb_queue_pkg;

  localparam int PRF_IDX_W = 6;
  localparam int ROB_IDX_W = 5;
  localparam int BR_MASK_W = 4;

  localparam logic [PRF_IDX_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                 vld;
    logic [PRF_IDX_W-1:0] tag;
    logic [63:0]          value;
    logic [ROB_IDX_W:0]   rob_idx;
    logic [BR_MASK_W-1:0] br_mask;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_squash.sv
// rtl/wbq_squash.sv - per-entry branch kill on recovery and mask-bit clear on correct prediction
module wbq_squash
  import fu_wb_queue_pkg::*;
(
  input  wbq_entry_t           entry_i,
  input  logic                 recovery_i,
  input  logic                 pred_correct_i,
  input  logic [BR_MASK_W-1:0] tag_fix_i,
  output wbq_entry_t           entry_o
);

  // Recovery wins over pred_correct; a killed entry keeps its payload but loses vld.
  always_comb begin
    entry_o = entry_i;
    if (recovery_i) begin
      if (|(entry_i.br_mask & tag_fix_i)) begin
        entry_o.vld = 1'b0;
      end
    end else if (pred_correct_i) begin
      entry_o.br_mask = entry_i.br_mask & ~tag_fix_i;
    end
  end

endmodule

// File: rtl/fu_wb_queue.sv
// rtl/fu_wb_queue.sv - collapsing age-ordered writeback queue; optional WBQ_BYPASS_EN empty-queue bypass
module fu_wb_queue
  import fu_wb_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int NUM_SRC = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SRC-1:0]                  src_vld_i,
  input  logic [NUM_SRC-1:0][PRF_IDX_W-1:0]   src_tag_i,
  input  logic [NUM_SRC-1:0][63:0]            src_value_i,
  input  logic [NUM_SRC-1:0][ROB_IDX_W:0]     src_rob_idx_i,
  input  logic [NUM_SRC-1:0][BR_MASK_W-1:0]   src_br_mask_i,
  output logic                                src_rdy_o,
  input  logic                                wb_stall_i,
  input  logic                                rob_br_recovery_i,
  input  logic                                rob_br_pred_correct_i,
  input  logic [BR_MASK_W-1:0]                rob_br_tag_fix_i,
  output logic                                wb_vld_o,
  output logic [PRF_IDX_W-1:0]                wb_tag_o,
  output logic [63:0]                         wb_value_o,
  output logic [ROB_IDX_W:0]                  wb_rob_idx_o,
  output logic [BR_MASK_W-1:0]                wb_br_mask_o,
  output logic [$clog2(DEPTH+1)-1:0]          count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int NCAND = DEPTH + NUM_SRC;
  localparam int POS_W = $clog2(NCAND+1);

  wbq_entry_t       q        [DEPTH];
  wbq_entry_t       shifted  [DEPTH];
  wbq_entry_t       src_raw  [NUM_SRC];
  wbq_entry_t       cand     [NCAND];
  wbq_entry_t       nxt      [DEPTH];
  logic [POS_W-1:0] pos      [NCAND];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] nxt_count;
  logic [NUM_SRC-1:0] accept;
  logic [NUM_SRC-1:0] bypass_sel;
  logic             deq;
  logic             bypass_hit;

  // Credit is judged on the registered count only, so a same-cycle dequeue never frees room.
  assign src_rdy_o = (count <= CNT_W'(DEPTH - NUM_SRC));
  assign accept    = src_vld_i & {NUM_SRC{src_rdy_o}};
  assign deq       = q[0].vld & ~wb_stall_i & ~rob_br_recovery_i;
  assign count_o   = count;

`ifdef WBQ_BYPASS_EN
  assign bypass_hit = rst_n & (count == '0) & ~wb_stall_i & ~rob_br_recovery_i & (|accept);
  assign bypass_sel = accept & (~accept + NUM_SRC'(1));
`else
  assign bypass_hit = 1'b0;
  assign bypass_sel = '0;
`endif

  // Pop the head: every survivor moves down one slot.
  always_comb begin
    for (int i = 0; i < DEPTH-1; i++) begin
      shifted[i] = deq ? q[i+1] : q[i];
    end
    shifted[DEPTH-1] = deq ? '0 : q[DEPTH-1];
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src_raw[g] = '{vld:     accept[g] & ~(bypass_hit & bypass_sel[g]),
                          tag:     src_tag_i[g],
                          value:   src_value_i[g],
                          rob_idx: src_rob_idx_i[g],
                          br_mask: src_br_mask_i[g]};

    wbq_squash u_squash_src (
      .entry_i        (src_raw[g]),
      .recovery_i     (rob_br_recovery_i),
      .pred_correct_i (rob_br_pred_correct_i),
      .tag_fix_i      (rob_br_tag_fix_i),
      .entry_o        (cand[DEPTH+g])
    );
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    wbq_squash u_squash_ent (
      .entry_i        (shifted[g]),
      .recovery_i     (rob_br_recovery_i),
      .pred_correct_i (rob_br_pred_correct_i),
      .tag_fix_i      (rob_br_tag_fix_i),
      .entry_o        (cand[g])
    );
  end

  // Compact surviving entries followed by new sources; each lands at its prefix count of valids.
  always_comb begin
    pos[0] = '0;
    for (int i = 1; i < NCAND; i++) begin
      pos[i] = pos[i-1] + POS_W'(cand[i-1].vld);
    end
    for (int j = 0; j < DEPTH; j++) begin
      nxt[j] = '0;
      for (int i = 0; i < NCAND; i++) begin
        if (cand[i].vld && (pos[i] == POS_W'(j))) begin
          nxt[j] = cand[i];
        end
      end
    end
    nxt_count = '0;
    for (int j = 0; j < DEPTH; j++) begin
      nxt_count = nxt_count + CNT_W'(nxt[j].vld);
    end
  end

  // Head drive: stored slot 0 first, otherwise the bypassed source; idle outputs are zero.
  always_comb begin
    wb_vld_o     = 1'b0;
    wb_tag_o     = ZERO_REG;
    wb_value_o   = '0;
    wb_rob_idx_o = '0;
    wb_br_mask_o = '0;
    if (deq) begin
      wb_vld_o     = 1'b1;
      wb_tag_o     = q[0].tag;
      wb_value_o   = q[0].value;
      wb_rob_idx_o = q[0].rob_idx;
      wb_br_mask_o = q[0].br_mask;
    end else if (bypass_hit) begin
      wb_vld_o = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bypass_sel[i]) begin
          wb_tag_o     = cand[DEPTH+i].tag;
          wb_value_o   = cand[DEPTH+i].value;
          wb_rob_idx_o = cand[DEPTH+i].rob_idx;
          wb_br_mask_o = cand[DEPTH+i].br_mask;
        end
      end
    end
  end

  // Storage and occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= nxt[i];
      end
      count <= nxt_count;
    end
  end

  // A producer must not fire while the queue withholds credit.
  assert property (@(posedge clk) disable iff (!rst_n) ((src_vld_i & ~{NUM_SRC{src_rdy_o}}) == '0));

endmodule

// File: tb/tb_fu_wb_queue.sv
// tb/tb_fu_wb_queue.sv - randomized and directed bench for fu_wb_queue against a queue-based model
module tb_fu_wb_queue;
  import fu_wb_queue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int NUM_SRC = 3;

  logic                              clk;
  logic                              rst_n;
  logic [NUM_SRC-1:0]                src_vld_i;
  logic [NUM_SRC-1:0][PRF_IDX_W-1:0] src_tag_i;
  logic [NUM_SRC-1:0][63:0]          src_value_i;
  logic [NUM_SRC-1:0][ROB_IDX_W:0]   src_rob_idx_i;
  logic [NUM_SRC-1:0][BR_MASK_W-1:0] src_br_mask_i;
  logic                              src_rdy_o;
  logic                              wb_stall_i;
  logic                              rob_br_recovery_i;
  logic                              rob_br_pred_correct_i;
  logic [BR_MASK_W-1:0]              rob_br_tag_fix_i;
  logic                              wb_vld_o;
  logic [PRF_IDX_W-1:0]              wb_tag_o;
  logic [63:0]                       wb_value_o;
  logic [ROB_IDX_W:0]                wb_rob_idx_o;
  logic [BR_MASK_W-1:0]              wb_br_mask_o;
  logic [$clog2(DEPTH+1)-1:0]        count_o;

  fu_wb_queue #(.DEPTH(DEPTH), .NUM_SRC(NUM_SRC)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .src_vld_i             (src_vld_i),
    .src_tag_i             (src_tag_i),
    .src_value_i           (src_value_i),
    .src_rob_idx_i         (src_rob_idx_i),
    .src_br_mask_i         (src_br_mask_i),
    .src_rdy_o             (src_rdy_o),
    .wb_stall_i            (wb_stall_i),
    .rob_br_recovery_i     (rob_br_recovery_i),
    .rob_br_pred_correct_i (rob_br_pred_correct_i),
    .rob_br_tag_fix_i      (rob_br_tag_fix_i),
    .wb_vld_o              (wb_vld_o),
    .wb_tag_o              (wb_tag_o),
    .wb_value_o            (wb_value_o),
    .wb_rob_idx_o          (wb_rob_idx_o),
    .wb_br_mask_o          (wb_br_mask_o),
    .count_o               (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [PRF_IDX_W-1:0] tag;
    logic [63:0]          value;
    logic [ROB_IDX_W:0]   rob;
    logic [BR_MASK_W-1:0] mask;
  } m_t;

  m_t mq[$];

  task automatic idle_inputs();
    src_vld_i             = '0;
    src_tag_i             = '0;
    src_value_i           = '0;
    src_rob_idx_i         = '0;
    src_br_mask_i         = '0;
    wb_stall_i            = 1'b0;
    rob_br_recovery_i     = 1'b0;
    rob_br_pred_correct_i = 1'b0;
    rob_br_tag_fix_i      = '0;
  endtask

  task automatic set_src(input int i, input logic [PRF_IDX_W-1:0] tag, input logic [63:0] val,
                         input logic [ROB_IDX_W:0] rob, input logic [BR_MASK_W-1:0] mask);
    src_vld_i[i]     = 1'b1;
    src_tag_i[i]     = tag;
    src_value_i[i]   = val;
    src_rob_idx_i[i] = rob;
    src_br_mask_i[i] = mask;
  endtask

  // One clock: compare outputs to the model mid-cycle, then advance the model at the edge.
  task automatic step(input string tname);
    m_t   head;
    m_t   e;
    m_t   nq[$];
    logic exp_vld;
    logic exp_rdy;
    int   byp_idx;
    #2;
    byp_idx = -1;
`ifdef WBQ_BYPASS_EN
    if (mq.size() == 0 && !wb_stall_i && !rob_br_recovery_i) begin
      for (int i = NUM_SRC-1; i >= 0; i--) begin
        if (src_vld_i[i]) byp_idx = i;
      end
    end
`endif
    exp_vld = (mq.size() > 0 && !wb_stall_i && !rob_br_recovery_i) || (byp_idx >= 0);
    head = '{tag: ZERO_REG, value: 64'd0, rob: '0, mask: '0};
    if (exp_vld && mq.size() > 0) begin
      head = mq[0];
    end else if (exp_vld) begin
      head = '{tag: src_tag_i[byp_idx], value: src_value_i[byp_idx],
               rob: src_rob_idx_i[byp_idx], mask: src_br_mask_i[byp_idx]};
      if (rob_br_pred_correct_i) head.mask = head.mask & ~rob_br_tag_fix_i;
    end
    exp_rdy = (mq.size() <= DEPTH - NUM_SRC);

    checks++;
    if (wb_vld_o !== exp_vld) begin
      errors++;
      $display("FAIL %s wb_vld got %0b exp %0b", tname, wb_vld_o, exp_vld);
    end
    checks++;
    if (wb_tag_o !== head.tag) begin
      errors++;
      $display("FAIL %s wb_tag got %0d exp %0d", tname, wb_tag_o, head.tag);
    end
    checks++;
    if (wb_value_o !== head.value) begin
      errors++;
      $display("FAIL %s wb_value got %0h exp %0h", tname, wb_value_o, head.value);
    end
    checks++;
    if (wb_rob_idx_o !== head.rob) begin
      errors++;
      $display("FAIL %s wb_rob_idx got %0d exp %0d", tname, wb_rob_idx_o, head.rob);
    end
    checks++;
    if (wb_br_mask_o !== head.mask) begin
      errors++;
      $display("FAIL %s wb_br_mask got %0b exp %0b", tname, wb_br_mask_o, head.mask);
    end
    checks++;
    if (count_o !== ($clog2(DEPTH+1))'(mq.size())) begin
      errors++;
      $display("FAIL %s count got %0d exp %0d", tname, count_o, mq.size());
    end
    checks++;
    if (src_rdy_o !== exp_rdy) begin
      errors++;
      $display("FAIL %s src_rdy got %0b exp %0b", tname, src_rdy_o, exp_rdy);
    end

    @(posedge clk);
    if (mq.size() > 0 && !wb_stall_i && !rob_br_recovery_i) void'(mq.pop_front());
    if (rob_br_recovery_i) begin
      nq = {};
      foreach (mq[k]) if ((mq[k].mask & rob_br_tag_fix_i) == '0) nq.push_back(mq[k]);
      mq = nq;
    end else if (rob_br_pred_correct_i) begin
      foreach (mq[k]) mq[k].mask = mq[k].mask & ~rob_br_tag_fix_i;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_vld_i[i] && i != byp_idx) begin
        e = '{tag: src_tag_i[i], value: src_value_i[i], rob: src_rob_idx_i[i], mask: src_br_mask_i[i]};
        if (rob_br_recovery_i) begin
          if ((e.mask & rob_br_tag_fix_i) == '0) mq.push_back(e);
        end else begin
          if (rob_br_pred_correct_i) e.mask = e.mask & ~rob_br_tag_fix_i;
          mq.push_back(e);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if (wb_vld_o !== 1'b0 || wb_tag_o !== ZERO_REG || wb_value_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_out got vld %0b tag %0d value %0h exp 0 0 0", wb_vld_o, wb_tag_o, wb_value_o);
    end
    checks++;
    if (count_o !== 3'd0 || src_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got count %0d rdy %0b exp 0 1", count_o, src_rdy_o);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    set_src(0, 6'd12, 64'hAB, 6'd5, 4'b0000);
    step("single_enq");
    idle_inputs();
    #1;
`ifndef WBQ_BYPASS_EN
    checks++;
    if (wb_vld_o !== 1'b1 || wb_tag_o !== 6'd12 || wb_value_o !== 64'hAB || wb_rob_idx_o !== 6'd5) begin
      errors++;
      $display("FAIL single_head got vld %0b tag %0d value %0h rob %0d exp 1 12 ab 5",
               wb_vld_o, wb_tag_o, wb_value_o, wb_rob_idx_o);
    end
`endif
    step("single_wb");
    checks++;
    if (count_o !== 3'd0) begin
      errors++;
      $display("FAIL single_drain count got %0d exp 0", count_o);
    end
  endtask

  task automatic test_burst();
    logic [PRF_IDX_W-1:0] exp_tags [3];
    exp_tags = '{6'd4, 6'd7, 6'd9};
    set_src(0, 6'd4, 64'h4444, 6'd1, 4'b0000);
    set_src(1, 6'd7, 64'h7777, 6'd2, 4'b0000);
    set_src(2, 6'd9, 64'h9999, 6'd3, 4'b0000);
    step("burst_enq");
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      #1;
`ifndef WBQ_BYPASS_EN
      checks++;
      if (wb_tag_o !== exp_tags[k] || wb_vld_o !== 1'b1) begin
        errors++;
        $display("FAIL burst_order[%0d] got vld %0b tag %0d exp 1 %0d", k, wb_vld_o, wb_tag_o, exp_tags[k]);
      end
      checks++;
      if (src_rdy_o !== (count_o <= 3'd1)) begin
        errors++;
        $display("FAIL burst_rdy[%0d] got %0b with count %0d exp %0b", k, src_rdy_o, count_o, count_o <= 3'd1);
      end
`endif
      step("burst_wb");
    end
  endtask

  task automatic test_recovery();
    set_src(0, 6'd21, 64'h21, 6'd10, 4'b0001);
    set_src(1, 6'd22, 64'h22, 6'd11, 4'b0010);
    set_src(2, 6'd23, 64'h23, 6'd12, 4'b0001);
    step("recov_enq");
    idle_inputs();
    rob_br_recovery_i = 1'b1;
    rob_br_tag_fix_i  = 4'b0001;
    #1;
    checks++;
    if (wb_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL recov_no_wb got %0b exp 0", wb_vld_o);
    end
    step("recov_cycle");
    idle_inputs();
    #1;
`ifndef WBQ_BYPASS_EN
    checks++;
    if (wb_vld_o !== 1'b1 || wb_tag_o !== 6'd22 || count_o !== 3'd1) begin
      errors++;
      $display("FAIL recov_survivor got vld %0b tag %0d count %0d exp 1 22 1", wb_vld_o, wb_tag_o, count_o);
    end
`endif
    step("recov_wb");
  endtask

  task automatic test_pred_correct();
    set_src(0, 6'd30, 64'h3030, 6'd7, 4'b0011);
    wb_stall_i = 1'b1;
    step("pc_enq");
    idle_inputs();
    wb_stall_i            = 1'b1;
    rob_br_pred_correct_i = 1'b1;
    rob_br_tag_fix_i      = 4'b0010;
    step("pc_clear");
    idle_inputs();
    #1;
    checks++;
    if (wb_vld_o !== 1'b1 || wb_br_mask_o !== 4'b0001) begin
      errors++;
      $display("FAIL pc_mask got vld %0b mask %0b exp 1 0001", wb_vld_o, wb_br_mask_o);
    end
    step("pc_wb");
  endtask

  task automatic test_stall();
    set_src(0, 6'd40, 64'h40, 6'd20, 4'b0000);
    set_src(1, 6'd41, 64'h41, 6'd21, 4'b0000);
    wb_stall_i = 1'b1;
    step("stall_enq");
    for (int k = 0; k < 2; k++) begin
      idle_inputs();
      wb_stall_i = 1'b1;
      #1;
      checks++;
      if (wb_vld_o !== 1'b0 || count_o !== 3'd2) begin
        errors++;
        $display("FAIL stall_hold[%0d] got vld %0b count %0d exp 0 2", k, wb_vld_o, count_o);
      end
      step("stall_hold");
    end
    idle_inputs();
    #1;
    checks++;
    if (wb_tag_o !== 6'd40 || wb_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_drain0 got vld %0b tag %0d exp 1 40", wb_vld_o, wb_tag_o);
    end
    step("stall_drain0");
    #1;
    checks++;
    if (wb_tag_o !== 6'd41 || wb_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_drain1 got vld %0b tag %0d exp 1 41", wb_vld_o, wb_tag_o);
    end
    step("stall_drain1");
  endtask

  task automatic test_reset_mid();
    set_src(0, 6'd50, 64'h50, 6'd1, 4'b0000);
    set_src(1, 6'd51, 64'h51, 6'd2, 4'b0000);
    set_src(2, 6'd52, 64'h52, 6'd3, 4'b0000);
    wb_stall_i = 1'b1;
    step("mid_enq");
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wb_vld_o !== 1'b0 || wb_tag_o !== ZERO_REG || count_o !== 3'd0 || src_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got vld %0b tag %0d count %0d rdy %0b exp 0 0 0 1",
               wb_vld_o, wb_tag_o, count_o, src_rdy_o);
    end
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (count_o !== 3'd0 || src_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_release got count %0d rdy %0b exp 0 1", count_o, src_rdy_o);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      wb_stall_i            = ($urandom_range(0, 3) == 0);
      rob_br_recovery_i     = ($urandom_range(0, 9) == 0);
      rob_br_pred_correct_i = ($urandom_range(0, 6) == 0);
      rob_br_tag_fix_i      = 4'b0001 << $urandom_range(0, 3);
      if (mq.size() <= DEPTH - NUM_SRC) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if ($urandom_range(0, 1) == 1) begin
            set_src(i, PRF_IDX_W'($urandom_range(1, 63)), {$urandom, $urandom},
                    (ROB_IDX_W+1)'($urandom_range(0, 63)),
                    ($urandom_range(0, 2) == 0) ? BR_MASK_W'($urandom_range(0, 15)) : 4'b0000);
          end
        end
      end
      step("random");
    end
    idle_inputs();
    for (int n = 0; n < DEPTH + 1; n++) step("random_drain");
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_recovery();
    test_pred_correct();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
